// File: rtl/mdl_dmadregseq_pkg.sv
// Shared definitions for the 005297 DMA byte-sequencing modules.
// Mode encodings, lane range and mode decode helper.
package mdl_dmadregseq_pkg;

   typedef enum logic [1:0] {
      MODE_NORM  = 2'b00,
      MODE_BOOT  = 2'b01,
      MODE_UPAGE = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_e;

   localparam int LANES_MIN = 2;
   localparam int LANES_MAX = 8;

   // Reserved encoding behaves as normal mode.
   function automatic mode_e decode_mode(input logic [1:0] m);
      mode_e r;
      case (m)
         2'b01:   r = MODE_BOOT;
         2'b10:   r = MODE_UPAGE;
         default: r = MODE_NORM;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mdl_dlcntr.sv
// Bootloader download counter.
// Load wins over decrement; decrement saturates at zero.
module mdl_dlcntr
   import mdl_dmadregseq_pkg::*;
#(
   parameter int W = 12
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   input  logic         ld_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic [W-1:0] cnt_o,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, else saturating decrement.
   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         if (ld_i) begin
            cnt_d = val_i;
         end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mdl_dmadregseq.sv
// DMA byte-to-lane sequencer with init skip, mode gating,
// word-ready handshake, overrun flag and download counter.
module mdl_dmadregseq
   import mdl_dmadregseq_pkg::*;
#(
   parameter int LANES     = 2,
   parameter int DLCNT_W   = 12,
   parameter int SKIP_INIT = 1
) (
   input  logic               i_MCLK,
   input  logic               i_SYS_RST_n,
   input  logic               i_CLK2M_PCEN_n,
   input  logic [1:0]         i_MODE,
   input  logic               i_ACQ_START,
   input  logic               i_BYTE_VALID,
   input  logic               i_VALPG_OK,
   input  logic               i_DLCNT_LD,
   input  logic [DLCNT_W-1:0] i_DLCNT_VAL,
   input  logic               i_WORD_ACK,
   input  logic               i_WORD_ABORT,
   output logic               o_NEWBYTE,
   output logic [LANES-1:0]   o_LANE_LD,
   output logic               o_WORD_RDY,
   output logic [DLCNT_W-1:0] o_DLCNT,
   output logic               o_DLCNT_ZERO,
   output logic               o_OVERRUN
);

   localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam logic [PW-1:0] LAST = PW'(LANES - 1);

   logic             en;
   mode_e            mode;
   logic             zero;
   logic             skip_hit;
   logic             gate;
   logic             pass;
   logic             blocked;
   logic             accept;
   logic [LANES-1:0] onehot;

   logic [PW-1:0]    ptr_q,     ptr_d;
   logic             skip_q,    skip_d;
   logic             newbyte_q, newbyte_d;
   logic [LANES-1:0] lane_q,    lane_d;
   logic             rdy_q,     rdy_d;
   logic             ovr_q,     ovr_d;

   assign en   = ~i_CLK2M_PCEN_n;
   assign mode = decode_mode(i_MODE);

   // Byte qualification: skip, mode gate, pending word, abort.
   always_comb begin
      skip_hit = (SKIP_INIT != 0) && skip_q && i_BYTE_VALID;
      unique case (mode)
         MODE_BOOT:  gate = ~zero;
         MODE_UPAGE: gate = i_VALPG_OK;
         default:    gate = 1'b1;
      endcase
      pass    = en && i_BYTE_VALID && !skip_hit && gate;
      blocked = rdy_q && !i_WORD_ACK;
      accept  = pass && !blocked && !i_WORD_ABORT;
      onehot  = '0;
      onehot[ptr_q] = 1'b1;
   end

   // Next state for pointer, strobes and flags.
   always_comb begin
      ptr_d     = ptr_q;
      skip_d    = skip_q;
      newbyte_d = newbyte_q;
      lane_d    = lane_q;
      rdy_d     = rdy_q;
      ovr_d     = ovr_q;
      if (en) begin
         if ((SKIP_INIT != 0) && i_ACQ_START) begin
            skip_d = 1'b1;
         end else if (i_BYTE_VALID) begin
            skip_d = 1'b0;
         end
         newbyte_d = accept;
         lane_d    = accept ? onehot : '0;
         if (i_WORD_ABORT) begin
            ptr_d = '0;
            rdy_d = 1'b0;
         end else if (accept) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
            if (ptr_q == LAST) begin
               rdy_d = 1'b1;
            end else if (i_WORD_ACK) begin
               rdy_d = 1'b0;
            end
         end else if (i_WORD_ACK) begin
            rdy_d = 1'b0;
         end
         if (i_ACQ_START) begin
            ovr_d = 1'b0;
         end else if (pass && blocked) begin
            ovr_d = 1'b1;
         end
      end
   end

   // State registers.
   always_ff @(posedge i_MCLK or negedge i_SYS_RST_n) begin
      if (!i_SYS_RST_n) begin
         ptr_q     <= '0;
         skip_q    <= 1'b0;
         newbyte_q <= 1'b0;
         lane_q    <= '0;
         rdy_q     <= 1'b0;
         ovr_q     <= 1'b0;
      end else begin
         ptr_q     <= ptr_d;
         skip_q    <= skip_d;
         newbyte_q <= newbyte_d;
         lane_q    <= lane_d;
         rdy_q     <= rdy_d;
         ovr_q     <= ovr_d;
      end
   end

   mdl_dlcntr #(
      .W (DLCNT_W)
   ) u_dlcntr (
      .clk_i  (i_MCLK),
      .rst_ni (i_SYS_RST_n),
      .en_i   (en),
      .ld_i   (i_DLCNT_LD),
      .val_i  (i_DLCNT_VAL),
      .dec_i  (accept && (mode == MODE_BOOT)),
      .cnt_o  (o_DLCNT),
      .zero_o (zero)
   );

   assign o_NEWBYTE    = newbyte_q;
   assign o_LANE_LD    = lane_q;
   assign o_WORD_RDY   = rdy_q;
   assign o_DLCNT_ZERO = zero;
   assign o_OVERRUN    = ovr_q;

endmodule

// File: tb/tb_mdl_dmadregseq.sv
// Scoreboard bench: a LANES=2 and a LANES=4 instance share
// stimulus; sel routes strobes/controls to one of them.
module tb_mdl_dmadregseq;

   typedef struct {
      logic [7:0]  lane;
      logic        rdy;
      logic [11:0] cnt;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        pcen_n;
   logic [1:0]  mode;
   logic        acq, bv, valpg, ld, ack, abort;
   logic [11:0] val;
   logic        sel;

   logic        nb_a, rdy_a, z_a, ovr_a;
   logic [1:0]  lane_a;
   logic [11:0] cnt_a;
   logic        nb_b, rdy_b, z_b, ovr_b;
   logic [3:0]  lane_b;
   logic [11:0] cnt_b;

   exp_t qa[$];
   exp_t qb[$];
   int   checks;
   int   failures;

   mdl_dmadregseq #(.LANES(2), .DLCNT_W(12), .SKIP_INIT(1)) dut_a (
      .i_MCLK         (clk),
      .i_SYS_RST_n    (rst_n),
      .i_CLK2M_PCEN_n (pcen_n),
      .i_MODE         (mode),
      .i_ACQ_START    (acq & ~sel),
      .i_BYTE_VALID   (bv & ~sel),
      .i_VALPG_OK     (valpg),
      .i_DLCNT_LD     (ld & ~sel),
      .i_DLCNT_VAL    (val),
      .i_WORD_ACK     (ack & ~sel),
      .i_WORD_ABORT   (abort & ~sel),
      .o_NEWBYTE      (nb_a),
      .o_LANE_LD      (lane_a),
      .o_WORD_RDY     (rdy_a),
      .o_DLCNT        (cnt_a),
      .o_DLCNT_ZERO   (z_a),
      .o_OVERRUN      (ovr_a)
   );

   mdl_dmadregseq #(.LANES(4), .DLCNT_W(12), .SKIP_INIT(1)) dut_b (
      .i_MCLK         (clk),
      .i_SYS_RST_n    (rst_n),
      .i_CLK2M_PCEN_n (pcen_n),
      .i_MODE         (mode),
      .i_ACQ_START    (acq & sel),
      .i_BYTE_VALID   (bv & sel),
      .i_VALPG_OK     (valpg),
      .i_DLCNT_LD     (ld & sel),
      .i_DLCNT_VAL    (val),
      .i_WORD_ACK     (ack & sel),
      .i_WORD_ABORT   (abort & sel),
      .o_NEWBYTE      (nb_b),
      .o_LANE_LD      (lane_b),
      .o_WORD_RDY     (rdy_b),
      .o_DLCNT        (cnt_b),
      .o_DLCNT_ZERO   (z_b),
      .o_OVERRUN      (ovr_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Monitor: every o_NEWBYTE pulse pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (nb_a) begin
         checks++;
         if (qa.size() == 0) begin
            failures++;
            $display("FAIL a_unexpected: lane=%b rdy=%b cnt=%0d, none required",
                     lane_a, rdy_a, cnt_a);
         end else begin
            e = qa.pop_front();
            if ({6'b0, lane_a} !== e.lane || rdy_a !== e.rdy || cnt_a !== e.cnt) begin
               failures++;
               $display("FAIL a_byte: lane=%b rdy=%b cnt=%0d, required lane=%b rdy=%b cnt=%0d",
                        lane_a, rdy_a, cnt_a, e.lane[1:0], e.rdy, e.cnt);
            end
         end
      end
      if (nb_b) begin
         checks++;
         if (qb.size() == 0) begin
            failures++;
            $display("FAIL b_unexpected: lane=%b rdy=%b cnt=%0d, none required",
                     lane_b, rdy_b, cnt_b);
         end else begin
            e = qb.pop_front();
            if ({4'b0, lane_b} !== e.lane || rdy_b !== e.rdy || cnt_b !== e.cnt) begin
               failures++;
               $display("FAIL b_byte: lane=%b rdy=%b cnt=%0d, required lane=%b rdy=%b cnt=%0d",
                        lane_b, rdy_b, cnt_b, e.lane[3:0], e.rdy, e.cnt);
            end
         end
      end
   end

   task automatic pa(input logic [7:0] l, input logic r, input logic [11:0] c);
      exp_t e;
      e.lane = l; e.rdy = r; e.cnt = c;
      qa.push_back(e);
   endtask

   task automatic pb(input logic [7:0] l, input logic r, input logic [11:0] c);
      exp_t e;
      e.lane = l; e.rdy = r; e.cnt = c;
      qb.push_back(e);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask

   // One clock period of stimulus, then return to idle.
   task automatic cyc(input logic b, input logic k, input logic ab, input logic s,
                      input logic l, input logic [11:0] v);
      bv = b; ack = k; abort = ab; acq = s; ld = l; val = v;
      @(posedge clk);
      #1;
      bv = 0; ack = 0; abort = 0; acq = 0; ld = 0; val = '0;
   endtask

   task automatic chk_reset(input string nm);
      chk({nm, "_nb_a"},   32'(nb_a),   0);
      chk({nm, "_lane_a"}, 32'(lane_a), 0);
      chk({nm, "_rdy_a"},  32'(rdy_a),  0);
      chk({nm, "_cnt_a"},  32'(cnt_a),  0);
      chk({nm, "_z_a"},    32'(z_a),    1);
      chk({nm, "_ovr_a"},  32'(ovr_a),  0);
      chk({nm, "_nb_b"},   32'(nb_b),   0);
      chk({nm, "_lane_b"}, 32'(lane_b), 0);
      chk({nm, "_rdy_b"},  32'(rdy_b),  0);
      chk({nm, "_cnt_b"},  32'(cnt_b),  0);
      chk({nm, "_z_b"},    32'(z_b),    1);
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 0; pcen_n = 0; mode = 2'b00; sel = 0;
      acq = 0; bv = 0; valpg = 0; ld = 0; val = '0; ack = 0; abort = 0;
      #12;
      chk_reset("rst");
      @(posedge clk); #1;
      rst_n = 1;

      // LANES=2, skip then two words with acks.
      sel = 0;
      cyc(0, 0, 0, 1, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      pa(8'b01, 0, 0); cyc(1, 1, 0, 0, 0, 0);
      pa(8'b10, 1, 0); cyc(1, 1, 0, 0, 0, 0);
      pa(8'b01, 0, 0); cyc(1, 1, 0, 0, 0, 0);
      pa(8'b10, 1, 0); cyc(1, 1, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk("ack_clr", 32'(rdy_a), 0);

      // Overrun: third byte with word pending.
      pa(8'b01, 0, 0); cyc(1, 0, 0, 0, 0, 0);
      pa(8'b10, 1, 0); cyc(1, 0, 0, 0, 0, 0);
      chk("rdy_after2", 32'(rdy_a), 1);
      cyc(1, 0, 0, 0, 0, 0);
      chk("ovr_set", 32'(ovr_a), 1);
      chk("ovr_rdy", 32'(rdy_a), 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk("ovr_sticky", 32'(ovr_a), 1);
      cyc(0, 0, 0, 1, 0, 0);
      chk("ovr_clr", 32'(ovr_a), 0);
      cyc(0, 1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0);

      // User page mode gated by VALPG_OK.
      mode = 2'b10;
      valpg = 1; pa(8'b01, 0, 0); cyc(1, 0, 0, 0, 0, 0);
      valpg = 0; cyc(1, 0, 0, 0, 0, 0);
      valpg = 1; pa(8'b10, 1, 0); cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 0, 0, 0, 0);
      valpg = 0;

      // Mode 11 acts as normal; disabled periods hold state.
      mode = 2'b11;
      pa(8'b01, 0, 0); cyc(1, 0, 0, 0, 0, 0);
      pa(8'b10, 1, 0); cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      pcen_n = 1;
      cyc(1, 1, 0, 0, 0, 0);
      chk("pcen_hold", 32'(rdy_a), 1);
      pcen_n = 0;
      cyc(0, 1, 0, 0, 0, 0);
      chk("pcen_ack", 32'(rdy_a), 0);

      // LANES=4 bootloader: count 3 allows three bytes.
      sel = 1; mode = 2'b01;
      cyc(0, 0, 0, 0, 1, 12'd3);
      chk("ld3", 32'(cnt_b), 3);
      chk("ld3_z", 32'(z_b), 0);
      pb(8'b0001, 0, 2); cyc(1, 0, 0, 0, 0, 0);
      pb(8'b0010, 0, 1); cyc(1, 0, 0, 0, 0, 0);
      pb(8'b0100, 0, 0); cyc(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
      chk("cnt0", 32'(cnt_b), 0);
      chk("cnt0_z", 32'(z_b), 1);
      chk("cnt0_ovr", 32'(ovr_b), 0);
      cyc(0, 0, 0, 0, 1, 12'd2);
      pb(8'b1000, 1, 7); cyc(1, 0, 0, 0, 1, 12'd7);
      chk("ld_over_dec", 32'(cnt_b), 7);
      cyc(0, 1, 0, 0, 0, 0);
      chk("ack_b", 32'(rdy_b), 0);

      // Abort coincident with a strobe.
      mode = 2'b00;
      pb(8'b0001, 0, 7); cyc(1, 0, 0, 0, 0, 0);
      pb(8'b0010, 0, 7); cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 0, 0, 0);
      chk("abort_rdy", 32'(rdy_b), 0);
      pb(8'b0001, 0, 7); cyc(1, 0, 0, 0, 0, 0);
      pb(8'b0010, 0, 7); cyc(1, 0, 0, 0, 0, 0);

      // Asynchronous reset mid-word while NEWBYTE is high.
      @(negedge clk); #1;
      rst_n = 0;
      #1;
      chk_reset("arst");
      @(posedge clk); #1;
      rst_n = 1;
      pb(8'b0001, 0, 0); cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("qa_empty", 32'(qa.size()), 0);
      chk("qb_empty", 32'(qb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mdl_dmadregseq.md
MDL_DMADREGSEQ -- requirements
Module: mdl_dmadregseq

Interface
REQ-001 SHALL have parameter LANES, default 2, which sets the number of byte lanes per DMA word (legal 2..8).
REQ-002 SHALL have parameter DLCNT_W, default 12, which sets the bootloader download counter width.
REQ-003 SHALL have parameter SKIP_INIT, default 1; when 1, the first byte after an acquisition start is discarded.
REQ-004 SHALL provide these ports (name, direction, width, meaning):
 i_MCLK  in  1  master clock
 i_SYS_RST_n  in  1  reset, asynchronous, active-low
 i_CLK2M_PCEN_n  in  1  clock enable, active-low; all state advances only on i_MCLK edges where it is 0
 i_MODE  in  2  00 normal, 01 bootloader, 10 user page, 11 treated as 00
 i_ACQ_START  in  1  acquisition start; arms the init skip
 i_BYTE_VALID  in  1  one-enable strobe: byte acquired
 i_VALPG_OK  in  1  user page valid (level)
 i_DLCNT_LD  in  1  load download counter
 i_DLCNT_VAL  in  DLCNT_W  counter load value
 i_WORD_ACK  in  1  consumer took the word
 i_WORD_ABORT  in  1  DMA word end/abort; returns to lane 0
 o_NEWBYTE  out  1  accepted-byte strobe
 o_LANE_LD  out  LANES  one-hot lane load enable
 o_WORD_RDY  out  1  word complete, awaiting ack
 o_DLCNT  out  DLCNT_W  download counter
 o_DLCNT_ZERO  out  1  counter equals 0
 o_OVERRUN  out  1  sticky: byte arrived while word pending

Function
REQ-005 Acceptance: a byte is accepted when the enable is active, i_BYTE_VALID=1, the byte is not skipped, and the mode gate passes; o_NEWBYTE SHALL be registered and high for exactly one enable period, one enable period after acceptance.
REQ-006 Init skip: when SKIP_INIT=1, i_ACQ_START SHALL set a skip flag; the next i_BYTE_VALID SHALL clear it and SHALL NOT be accepted; if i_ACQ_START and i_BYTE_VALID occur in the same enable period, the flag SHALL end set (start wins).
REQ-007 Mode gate: in mode 00 all bytes pass; in mode 10 a byte passes only when i_VALPG_OK=1; in mode 01 a byte passes only when o_DLCNT_ZERO=0.
REQ-008 Lane pointer: o_LANE_LD SHALL be one-hot, asserted together with o_NEWBYTE only (all zero otherwise), indicating the lane being loaded; after each accepted byte the pointer SHALL advance by one lane, wrapping from LANES-1 to 0.
REQ-009 Word completion: acceptance into lane LANES-1 SHALL set o_WORD_RDY in the same period that o_NEWBYTE pulses; i_WORD_ACK SHALL clear o_WORD_RDY; if ack and a new lane-0 byte coincide, the byte SHALL be accepted and o_WORD_RDY cleared.
REQ-010 Overrun: when i_BYTE_VALID passes the gate while o_WORD_RDY=1 and there is no i_WORD_ACK, the byte SHALL be dropped (pointer unchanged) and o_OVERRUN SHALL set; o_OVERRUN SHALL clear only on i_ACQ_START or reset.
REQ-011 Abort: i_WORD_ABORT SHALL return the pointer to lane 0 and clear o_WORD_RDY; it overrides a coincident acceptance, which is dropped.
REQ-012 Counter: i_DLCNT_LD SHALL load i_DLCNT_VAL; otherwise, in mode 01, each accepted byte SHALL decrement the counter by 1, saturating at 0; load overrides decrement.
REQ-013 o_DLCNT_ZERO SHALL be combinational (o_DLCNT==0); after the byte that takes the count 1->0 is accepted, no further bytes SHALL be accepted in mode 01.
REQ-014 A mode change SHALL take effect on the next enable period and SHALL NOT move the lane pointer.

Reset
REQ-015 On i_SYS_RST_n=0, asynchronously: pointer at lane 0, o_NEWBYTE=0, o_LANE_LD=0, o_WORD_RDY=0, o_OVERRUN=0, skip flag=0, o_DLCNT=0 (so o_DLCNT_ZERO=1).
REQ-016 A reset asserted mid-word SHALL discard the partial word; the first accepted byte after release SHALL go to lane 0.

Structure
REQ-017 The mode encodings and the LANES legal range SHALL live in the shared package used by the 005297 modules.
REQ-018 The download counter SHALL be a single sub-module, mdl_dlcntr (load, decrement-enable, saturate, zero flag); everything else is flat.

Verification
REQ-019 LANES=2, mode 00, SKIP_INIT=1: ACQ_START, then 5 BYTE_VALID strobes with acks -> byte 1 dropped, lane loads 01,10,01,10, and o_WORD_RDY rises twice.
REQ-020 LANES=4, mode 01, DLCNT loaded 3, 6 strobes -> 3 accepted, o_DLCNT 3->2->1->0, o_DLCNT_ZERO=1, strobes 4-6 ignored.
REQ-021 LANES=2, 3 strobes with no ack -> o_WORD_RDY=1 after strobe 2, strobe 3 dropped, o_OVERRUN=1 until next ACQ_START.
REQ-022 Mode 10, toggle i_VALPG_OK 1,0,1 over 3 strobes -> only strobes 1 and 3 accepted, loading lanes 0 and 1.
REQ-023 LANES=4: load 2 bytes, then assert i_WORD_ABORT coincident with a strobe -> that byte is dropped and the next accepted byte loads lane 0.
REQ-024 Assert i_SYS_RST_n low between enables mid-word -> all outputs reach their reset values immediately, without waiting for an i_MCLK edge.
